// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive sequencer: FSM state encoding,
// Ethernet preamble/SFD bytes, byte-counter width and a saturating increment.
package rgmii_pkg;

  localparam int unsigned CNT_W = 11;

  localparam logic [7:0] ETH_PRE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rgmii_rx_nibble_pack.sv
// Byte-lane formation for the RGMII receive path.
// Gigabit: one byte per clk from {rxd_q2, rxd_q1}. 10/100: two consecutive
// rxd_q1 nibbles, low nibble first. All outputs are registered.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   gmii_mode           1 = gigabit lanes, 0 = nibble assembly
//   rxd_q1/rxd_q2       rising/falling-edge data nibbles
//   ctl_q1/ctl_q2       rising/falling-edge RX_CTL
//   rx_byte, byte_v     assembled byte and its completion strobe
//   dv, er              data valid / receive error for the current clk
//   part                a lone low nibble was discarded when dv fell
module rgmii_rx_nibble_pack (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gmii_mode,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       ctl_q1,
  input  logic       ctl_q2,
  output logic [7:0] rx_byte,
  output logic       byte_v,
  output logic       dv,
  output logic       er,
  output logic       part
);

  logic [3:0] lo_nib;
  logic       phase;

  // Lane formation; phase marks a pending low nibble in 10/100 mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte <= '0;
      byte_v  <= 1'b0;
      dv      <= 1'b0;
      er      <= 1'b0;
      part    <= 1'b0;
      lo_nib  <= '0;
      phase   <= 1'b0;
    end else if (gmii_mode) begin
      rx_byte <= {rxd_q2, rxd_q1};
      byte_v  <= ctl_q1;
      dv      <= ctl_q1;
      er      <= ctl_q1 ^ ctl_q2;
      part    <= 1'b0;
      phase   <= 1'b0;
    end else begin
      dv     <= ctl_q1;
      er     <= ctl_q1 ^ ctl_q2;
      byte_v <= 1'b0;
      part   <= 1'b0;
      if (ctl_q1) begin
        if (phase) begin
          rx_byte <= {rxd_q1, lo_nib};
          byte_v  <= 1'b1;
          phase   <= 1'b0;
        end else begin
          lo_nib <= rxd_q1;
          phase  <= 1'b1;
        end
      end else begin
        part  <= phase;
        phase <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rgmii_rx_seq.sv
// RGMII receive sequencer: strips preamble/SFD, streams frame bytes with
// tlast on the final byte and tuser flagging errors, length overrun or a
// dangling nibble. Optional statistics under macro RGMII_RX_SEQ_STATS_EN.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   rxd_q1/rxd_q2, ctl_q1/ctl_q2 DDR-captured RGMII data and control
//   gmii_mode_i                  1 = gigabit, 0 = 10/100 (sampled in IDLE)
//   m_tdata_o/tvalid/tlast/tuser output byte stream (never stalls)
//   busy_o                       FSM is not IDLE
//   stat_good_o/stat_bad_o       (macro only) good / bad frame counters
module rgmii_rx_seq
  import rgmii_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned MIN_PRE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       ctl_q1,
  input  logic       ctl_q2,
  input  logic       gmii_mode_i,
  output logic [7:0] m_tdata_o,
  output logic       m_tvalid_o,
  output logic       m_tlast_o,
  output logic       m_tuser_o,
  output logic       busy_o
`ifdef RGMII_RX_SEQ_STATS_EN
  ,
  output logic [31:0] stat_good_o,
  output logic [31:0] stat_bad_o
`endif
);

  rx_state_e        state, state_d;
  logic [CNT_W-1:0] pre_cnt, pre_cnt_d;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_d;
  logic [7:0]       hold, hold_d;
  logic             hold_v, hold_v_d;
  logic             err, err_d;
  logic             tl_pend, tl_pend_d;
  logic             mode_q, mode_d;
  logic [7:0]       tdata_d;
  logic             tvalid_d, tlast_d, tuser_d;
  logic             mode_c;

  logic [7:0] p_byte;
  logic       p_v, p_dv, p_er, p_part;

  // Lane mode follows the input only while idle, frozen for the frame.
  assign mode_c = (state == ST_IDLE) ? gmii_mode_i : mode_q;

  rgmii_rx_nibble_pack u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .gmii_mode (mode_c),
    .rxd_q1    (rxd_q1),
    .rxd_q2    (rxd_q2),
    .ctl_q1    (ctl_q1),
    .ctl_q2    (ctl_q2),
    .rx_byte   (p_byte),
    .byte_v    (p_v),
    .dv        (p_dv),
    .er        (p_er),
    .part      (p_part)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pre_cnt    <= '0;
      byte_cnt   <= '0;
      hold       <= '0;
      hold_v     <= 1'b0;
      err        <= 1'b0;
      tl_pend    <= 1'b0;
      mode_q     <= 1'b1;
      m_tdata_o  <= '0;
      m_tvalid_o <= 1'b0;
      m_tlast_o  <= 1'b0;
      m_tuser_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_d;
      pre_cnt    <= pre_cnt_d;
      byte_cnt   <= byte_cnt_d;
      hold       <= hold_d;
      hold_v     <= hold_v_d;
      err        <= err_d;
      tl_pend    <= tl_pend_d;
      mode_q     <= mode_d;
      m_tdata_o  <= tdata_d;
      m_tvalid_o <= tvalid_d;
      m_tlast_o  <= tlast_d;
      m_tuser_o  <= tuser_d;
      busy_o     <= (state_d != ST_IDLE);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state;
    pre_cnt_d  = pre_cnt;
    byte_cnt_d = byte_cnt;
    hold_d     = hold;
    hold_v_d   = hold_v;
    err_d      = err;
    tl_pend_d  = tl_pend;
    mode_d     = mode_q;
    tdata_d    = m_tdata_o;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        mode_d = gmii_mode_i;
        // Deferred final byte: keeps 10/100 beats two clks apart.
        if (tl_pend) begin
          tvalid_d  = 1'b1;
          tdata_d   = hold;
          tlast_d   = 1'b1;
          tuser_d   = err;
          tl_pend_d = 1'b0;
          hold_v_d  = 1'b0;
        end
        if (p_dv && p_v) begin
          if (p_byte == ETH_PRE) begin
            state_d   = ST_PRE;
            pre_cnt_d = CNT_W'(1);
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PRE: begin
        if (!p_dv) begin
          state_d = ST_IDLE;
        end else if (p_v) begin
          if (p_byte == ETH_PRE) begin
            pre_cnt_d = sat_inc(pre_cnt);
          end else if (p_byte == ETH_SFD && pre_cnt >= CNT_W'(MIN_PRE)) begin
            state_d    = ST_DATA;
            byte_cnt_d = '0;
            err_d      = 1'b0;
            hold_v_d   = 1'b0;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_DATA: begin
        if (!p_dv) begin
          state_d = ST_IDLE;
          if (hold_v) begin
            if (!mode_q && m_tvalid_o) begin
              tl_pend_d = 1'b1;
              err_d     = err | p_part;
            end else begin
              tvalid_d = 1'b1;
              tdata_d  = hold;
              tlast_d  = 1'b1;
              tuser_d  = err | p_part;
              hold_v_d = 1'b0;
            end
          end
        end else begin
          if (p_er) begin
            err_d = 1'b1;
          end
          if (p_v) begin
            if (byte_cnt >= CNT_W'(MAX_LEN)) begin
              // Overrun: close the frame on the held byte, discard the rest.
              state_d  = ST_DROP;
              hold_v_d = 1'b0;
              if (hold_v) begin
                tvalid_d = 1'b1;
                tdata_d  = hold;
                tlast_d  = 1'b1;
                tuser_d  = 1'b1;
              end
            end else begin
              if (hold_v) begin
                tvalid_d = 1'b1;
                tdata_d  = hold;
              end
              hold_d     = p_byte;
              hold_v_d   = 1'b1;
              byte_cnt_d = sat_inc(byte_cnt);
            end
          end
        end
      end

      ST_DROP: begin
        if (!p_dv) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RGMII_RX_SEQ_STATS_EN
  logic good_ev, bad_ev;

  assign good_ev = tvalid_d && tlast_d && !tuser_d;
  assign bad_ev  = (tvalid_d && tlast_d && tuser_d) ||
                   (state_d == ST_DROP && state != ST_DROP);

  // Frame statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good_o <= '0;
      stat_bad_o  <= '0;
    end else begin
      if (good_ev) stat_good_o <= stat_good_o + 32'd1;
      if (bad_ev)  stat_bad_o  <= stat_bad_o + 32'd1;
    end
  end
`else
  // Statistics counters not built in this configuration.
`endif

endmodule

// File: tb/tb_rgmii_rx_seq.sv
// Directed testbench for rgmii_rx_seq: gigabit and 10/100 frames, error,
// short preamble, length overrun and mid-frame reset.
module tb_rgmii_rx_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rxd_q1, rxd_q2;
  logic       ctl_q1, ctl_q2;
  logic       gmii_mode_i;
  logic [7:0] m_tdata_o;
  logic       m_tvalid_o, m_tlast_o, m_tuser_o, busy_o;
`ifdef RGMII_RX_SEQ_STATS_EN
  logic [31:0] stat_good_o, stat_bad_o;
`endif

  rgmii_rx_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd_q1      (rxd_q1),
    .rxd_q2      (rxd_q2),
    .ctl_q1      (ctl_q1),
    .ctl_q2      (ctl_q2),
    .gmii_mode_i (gmii_mode_i),
    .m_tdata_o   (m_tdata_o),
    .m_tvalid_o  (m_tvalid_o),
    .m_tlast_o   (m_tlast_o),
    .m_tuser_o   (m_tuser_o),
    .busy_o      (busy_o)
`ifdef RGMII_RX_SEQ_STATS_EN
    ,
    .stat_good_o (stat_good_o),
    .stat_bad_o  (stat_bad_o)
`endif
  );

  always #5 clk = ~clk;

  int ncheck = 0;
  int npass  = 0;
  int cyc    = 0;

  logic [7:0] beat_d[$];
  logic       beat_l[$];
  logic       beat_u[$];
  int         beat_c[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_tvalid_o) begin
      beat_d.push_back(m_tdata_o);
      beat_l.push_back(m_tlast_o);
      beat_u.push_back(m_tuser_o);
      beat_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncheck++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      npass++;
  endtask

  task automatic clear_beats();
    beat_d.delete();
    beat_l.delete();
    beat_u.delete();
    beat_c.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd_q1 = 4'h0; rxd_q2 = 4'h0; ctl_q1 = 1'b0; ctl_q2 = 1'b0;
    end
  endtask

  task automatic gig_byte(input logic [7:0] b, input logic er);
    @(negedge clk);
    rxd_q1 = b[3:0]; rxd_q2 = b[7:4]; ctl_q1 = 1'b1; ctl_q2 = 1'b1 ^ er;
  endtask

  task automatic nib(input logic [3:0] v, input logic er);
    @(negedge clk);
    rxd_q1 = v; rxd_q2 = 4'h0; ctl_q1 = 1'b1; ctl_q2 = 1'b1 ^ er;
  endtask

  task automatic mii_byte(input logic [7:0] b);
    nib(b[3:0], 1'b0);
    nib(b[7:4], 1'b0);
  endtask

  // Gigabit frame: npre preamble bytes, SFD, n payload bytes i[7:0].
  task automatic gig_frame(input int npre, input int n, input int er_idx, input int flip_idx);
    for (int i = 0; i < npre; i++) gig_byte(8'h55, 1'b0);
    gig_byte(8'hD5, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == flip_idx) gmii_mode_i = 1'b0;
      gig_byte(8'(i), i == er_idx);
      exp_q.push_back(8'(i));
    end
    idle(6);
    gmii_mode_i = 1'b1;
  endtask

  task automatic mii_frame(input logic extra);
    logic [7:0] pay[3];
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    gmii_mode_i = 1'b0;
    idle(3);
    for (int i = 0; i < 7; i++) mii_byte(8'h55);
    mii_byte(8'hD5);
    for (int i = 0; i < 3; i++) begin
      mii_byte(pay[i]);
      exp_q.push_back(pay[i]);
    end
    if (extra) nib(4'h7, 1'b0);
    idle(6);
    gmii_mode_i = 1'b1;
    idle(3);
  endtask

  task automatic check_frame(input string tag, input int n_exp, input logic user_exp);
    int n, bad_d, bad_l;
    n = beat_d.size();
    bad_d = 0; bad_l = 0;
    check({tag, "_beats"}, 32'(n), 32'(n_exp));
    for (int i = 0; i < n && i < n_exp && i < exp_q.size(); i++) begin
      if (beat_d[i] !== exp_q[i]) bad_d++;
      if (beat_l[i] !== (i == n_exp - 1)) bad_l++;
    end
    check({tag, "_data_errs"}, 32'(bad_d), 32'd0);
    check({tag, "_tlast_errs"}, 32'(bad_l), 32'd0);
    check({tag, "_tuser"}, (n > 0) ? {31'd0, beat_u[n-1]} : 32'hDEAD, {31'd0, user_exp});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, {31'd0, m_tvalid_o}, 32'd0);
    check({tag, "_tlast"},  {31'd0, m_tlast_o},  32'd0);
    check({tag, "_tuser"},  {31'd0, m_tuser_o},  32'd0);
    check({tag, "_busy"},   {31'd0, busy_o},     32'd0);
    check({tag, "_tdata"},  {24'd0, m_tdata_o},  32'd0);
  endtask

  initial begin
    int gaps, lasts, pre_n;
    rst_n = 1'b0;
    rxd_q1 = 4'h0; rxd_q2 = 4'h0; ctl_q1 = 1'b0; ctl_q2 = 1'b0;
    gmii_mode_i = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
`ifdef RGMII_RX_SEQ_STATS_EN
    check("reset_stat_good", stat_good_o, 32'd0);
    check("reset_stat_bad",  stat_bad_o,  32'd0);
`endif
    rst_n = 1'b1;
    idle(3);

    // Clean gigabit frame; mode input toggled mid-frame must be ignored.
    clear_beats();
    gig_frame(7, 64, -1, 20);
    check_frame("gig_good", 64, 1'b0);
    check("gig_good_busy_after", {31'd0, busy_o}, 32'd0);

    // Receive error on byte 10.
    clear_beats();
    gig_frame(7, 64, 10, -1);
    check_frame("gig_err", 64, 1'b1);

    // 10/100 frame, whole bytes, beats two clks apart.
    clear_beats();
    mii_frame(1'b0);
    check_frame("mii_good", 3, 1'b0);
    gaps = 0;
    for (int i = 1; i < beat_c.size(); i++)
      if (beat_c[i] - beat_c[i-1] != 2) gaps++;
    check("mii_good_spacing_errs", 32'(gaps), 32'd0);

    // 10/100 frame with a trailing odd nibble.
    clear_beats();
    mii_frame(1'b1);
    check_frame("mii_odd", 3, 1'b1);

    // Short preamble: dropped, busy until dv falls.
    clear_beats();
    gig_byte(8'h55, 1'b0);
    gig_byte(8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) gig_byte(8'(i + 8'h40), 1'b0);
    #1 check("short_pre_busy", {31'd0, busy_o}, 32'd1);
    idle(6);
    check("short_pre_beats", 32'(beat_d.size()), 32'd0);
    check("short_pre_busy_after", {31'd0, busy_o}, 32'd0);

    // Length overrun, then a normal frame.
    clear_beats();
    gig_frame(7, 1600, -1, -1);
    check_frame("overrun", 1522, 1'b1);
    clear_beats();
    gig_frame(7, 64, -1, -1);
    check_frame("after_overrun", 64, 1'b0);

    // Reset pulsed at frame byte 30.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(3);
    clear_beats();
    for (int i = 0; i < 7; i++) gig_byte(8'h55, 1'b0);
    gig_byte(8'hD5, 1'b0);
    for (int i = 0; i < 31; i++) gig_byte(8'(i), 1'b0);
    #3 rst_n = 1'b0;
    #2 check_idle_outputs("midrst");
    pre_n = beat_d.size();
    gig_byte(8'd31, 1'b0);
    #3 rst_n = 1'b1;
    for (int i = 32; i < 64; i++) gig_byte(8'(i), 1'b0);
    #1 check("midrst_drop_busy", {31'd0, busy_o}, 32'd1);
    idle(6);
    lasts = 0;
    foreach (beat_l[i]) if (beat_l[i]) lasts++;
    check("midrst_tlast_count", 32'(lasts), 32'd0);
    check("midrst_extra_beats", 32'(beat_d.size() - pre_n), 32'd0);
    clear_beats();
    gig_frame(7, 64, -1, -1);
    check_frame("after_midrst", 64, 1'b0);
`ifdef RGMII_RX_SEQ_STATS_EN
    check("stat_good", stat_good_o, 32'd1);
    check("stat_bad",  stat_bad_o,  32'd1);
`endif

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_seq.md
RGMII_RX_SEQ -- requirements
Module: rgmii_rx_seq

Interface
REQ-001 Parameter MAX_LEN, default 1522, maximum accepted frame length in bytes (after SFD, including FCS).
REQ-002 Parameter MIN_PRE, default 2, minimum number of 0x55 preamble bytes required before SFD.
REQ-003 Port clk  in  1  the DDR-input output clock. All logic is in this one clock domain.
REQ-004 Port rst_n  in  1  asynchronous active-low reset.
REQ-005 Port rxd_q1  in  4  rising-edge nibble from the DDR input.
REQ-006 Port rxd_q2  in  4  falling-edge nibble from the DDR input.
REQ-007 Port ctl_q1  in  1  rising-edge RX_CTL, which is RX_DV.
REQ-008 Port ctl_q2  in  1  falling-edge RX_CTL, which is RX_DV xor RX_ER.
REQ-009 Port gmii_mode_i  in  1  1 = gigabit (byte per clk); 0 = 10/100 (nibble per clk, q1 only). Sampled only in IDLE.
REQ-010 Port m_tdata_o  out  8  received byte.
REQ-011 Port m_tvalid_o  out  1  byte valid. There is no ready input, and the stream never stalls.
REQ-012 Port m_tlast_o  out  1  last byte of frame.
REQ-013 Port m_tuser_o  out  1  frame error, qualified with m_tlast_o.
REQ-014 Port busy_o  out  1  state is not IDLE.

Function
REQ-015 The block SHALL form byte lanes as follows.
- Gigabit: byte = {rxd_q2, rxd_q1}, dv = ctl_q1, er = ctl_q1 ^ ctl_q2.
- 10/100: byte assembled low nibble first from two consecutive rxd_q1 samples, with dv/er taken per nibble.
REQ-016 The FSM SHALL have states IDLE, PRE, DATA, DROP.
REQ-017 IDLE transitions to PRE when dv=1 and the byte is 0x55. When dv=1 and the byte is anything else, it transitions to DROP.
REQ-018 In PRE, the block SHALL count 0x55 bytes.
- Byte 0xD5 with count >= MIN_PRE: go to DATA.
- Byte 0xD5 with count < MIN_PRE: go to DROP.
- Any other byte: go to DROP.
- dv=0: go to IDLE.
- No output is produced in PRE.
REQ-019 In DATA, each byte SHALL be held one byte-slot in a holding register and emitted when the next byte arrives or when dv falls. This lets m_tlast_o accompany the final byte.
REQ-020 Output latency SHALL be one byte-slot plus one clk from byte completion to m_tvalid_o.
REQ-021 When dv falls in DATA, the held byte SHALL be emitted with m_tlast_o=1, and the FSM SHALL return to IDLE.
REQ-022 When er=1 while dv=1 in DATA, a sticky error flag SHALL be set. It is reported as m_tuser_o=1 on the tlast beat.
REQ-023 When the byte count would exceed MAX_LEN, the held byte SHALL be emitted with m_tlast_o=1 and m_tuser_o=1, and the FSM SHALL go to DROP.
REQ-024 In 10/100 mode, if dv falls after an odd number of nibbles, the final partial nibble SHALL be discarded, and tlast SHALL carry m_tuser_o=1.
REQ-025 DROP SHALL emit nothing and return to IDLE on the first clk with dv=0.
REQ-026 A frame whose dv falls before any DATA byte is held SHALL produce no output beats.
REQ-027 m_tvalid_o SHALL be high for exactly one clk per byte. In 10/100 mode this is at most every second clk.
REQ-028 The byte counter SHALL be 11 bits wide, saturating at 2047. It is cleared on entry to DATA.
REQ-029 A change of gmii_mode_i outside IDLE SHALL have no effect until the next IDLE.

Reset
REQ-030 Asserting rst_n low SHALL put the FSM in IDLE and clear m_tvalid_o, m_tlast_o, m_tuser_o, busy_o, m_tdata_o, counters, the holding register, and the error flag.
REQ-031 Reset asserted mid-frame SHALL emit no tlast. After rst_n deasserts with dv=1 and non-preamble data, the FSM SHALL enter DROP.

Configuration
REQ-032 With macro RGMII_RX_SEQ_STATS_EN defined, the block SHALL add outputs stat_good_o (32 bits) and stat_bad_o (32 bits).
- They count tlast beats with tuser=0 and tuser=1, plus DROP entries.
- Both wrap modulo 2^32 and reset to 0.
- Without the macro, the ports and counters SHALL be absent.

Structure
REQ-033 A shared package rgmii_pkg SHALL hold the FSM state enum, ETH_PRE=8'h55, ETH_SFD=8'hD5, and the byte-counter width.
REQ-034 One sub-module rgmii_rx_nibble_pack SHALL perform the REQ-015 lane formation. It outputs byte, byte_v, dv, er, and a partial-nibble flag.

Verification
REQ-035 Gigabit, 7x0x55 + 0xD5 + 64 bytes 0x00..0x3F, dv then low: expect 64 beats, data 0x00..0x3F, tlast on 0x3F, tuser=0.
REQ-036 Gigabit, same frame with er asserted on byte 10: expect 64 beats, tlast tuser=1.
REQ-037 10/100, 7x0x55 + 0xD5 + 3 bytes A1,B2,C3 as nibbles low-first: expect beats A1,B2,C3 on every other clk, tlast on C3, tuser=0. Add one extra nibble: expect tuser=1.
REQ-038 Gigabit, 1x0x55 + 0xD5 + 20 bytes with MIN_PRE=2: expect no beats and busy_o high until dv=0.
REQ-039 Gigabit, 1600-byte frame with MAX_LEN=1522: expect 1522 beats, tlast+tuser on beat 1522, nothing further; next valid frame is received normally.
REQ-040 rst_n pulsed low at frame byte 30: expect all outputs 0; the remainder of that frame produces no beats; the next frame is received intact. With STATS_EN: stat_good_o=1, stat_bad_o=1.
